ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Shares the single-port-pair 64x16 data RAM (one synchronous read port, one write port, read-first) between NUM_REQ requesters, e.g. datapath/ALU operand fetch, writeback, debug/loader.
- Read and write channels are arbitrated independently, round-robin, one grant per channel per cycle.
- After reset, an optional clear sequencer walks all 64 words (including register-bank words 60-63: D, C, B, A) before normal grants begin.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- CLEAR_ON_RESET, 1: 1 = write INIT_VALUE to all 64 words after reset; 0 = go straight to RUN.
- INIT_VALUE, 16'h0000: word written during the clear sequence.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  NUM_REQ  per-requester read request, held until granted.
- rd_addr  in  6*NUM_REQ  read address, requester i at [6i+5:6i].
- rd_gnt  out  NUM_REQ  one-hot read grant, combinational, same cycle as accepted request.
- rd_valid  out  NUM_REQ  one-hot, asserted the cycle after rd_gnt[i].
- rd_data  out  16  shared read data, qualified by rd_valid.
- wr_req  in  NUM_REQ  per-requester write request, held until granted.
- wr_addr  in  6*NUM_REQ  write address.
- wr_data  in  16*NUM_REQ  write data.
- wr_gnt  out  NUM_REQ  one-hot write grant, combinational; write is committed at that clock edge.
- init_done  out  1  high in RUN state.
- ram_read  out  1  RAM read strobe.
- ram_read_addr  out  6  RAM read address.
- ram_write  out  1  RAM write strobe.
- ram_write_addr  out  6  RAM write address.
- ram_data_in  out  16  RAM write data.
- ram_data_out  in  16  RAM registered read data.

Behaviour:
- Reset values (async on rst_n low):
  - rd_ptr = wr_ptr = 0; rd_valid = 0; clr_cnt = 0.
  - state = INIT if CLEAR_ON_RESET, else RUN.
  - While rst_n is low, rd_gnt, wr_gnt, ram_read and ram_write are forced 0 combinationally, and init_done = 0.
- FSM INIT:
  - ram_write = 1, ram_write_addr = clr_cnt, ram_data_in = INIT_VALUE; clr_cnt increments each cycle.
  - After the cycle writing address 63, the next state is RUN. INIT lasts exactly 64 cycles.
  - All grants are 0 and ram_read = 0. Requests stay pending.
- FSM RUN:
  - Terminal until reset. init_done = 1.
- Round-robin arbitration, per channel:
  - The search starts at ptr and wraps modulo NUM_REQ; the first requester with req set is granted.
  - On a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
  - A lone requester is granted every cycle (no bubbles).
- Read path:
  - On grant i: ram_read = 1, ram_read_addr = rd_addr[i], rd_owner <= i.
  - Next cycle: rd_valid[i] = 1 and rd_data = ram_data_out. Latency is 1 cycle; back-to-back reads give one result per cycle.
  - With no read grant, ram_read = 0, rd_valid = 0 next cycle, and rd_data holds the RAM output (don't-care).
- Write path:
  - On grant i: ram_write = 1, ram_write_addr = wr_addr[i], ram_data_in = wr_data[i]. No response signal.
- Hazards:
  - Read and write to the same address in the same cycle return OLD data (RAM is read-first). No forwarding.
  - A read granted the cycle after a write to the same address returns the new data.
- Reset mid-operation:
  - A pending rd_valid is dropped; the read result is lost.
  - INIT restarts from address 0.
- Outside INIT, no RAM strobe asserts without a corresponding grant.

Decomposition:
- Shared include ram_ctrl_defs.vh:
  - RAM_ADDR_W = 6, RAM_DATA_W = 16, RAM_DEPTH = 64.
  - REG_A_ADDR = 63, REG_B_ADDR = 62, REG_C_ADDR = 61, REG_D_ADDR = 60.
  - FSM encodings ST_INIT = 1'b0, ST_RUN = 1'b1.
- Sub-module rr_arbiter (NUM_REQ param): req vector in, one-hot gnt out, owns ptr with async reset. Instantiated twice, once for read, once for write.
- The top level holds the FSM, clear counter, address/data muxing and rd_valid/owner register.
- The bench instantiates the existing 64x16 RAM as the real memory model.

Test Plan:
- CLEAR_ON_RESET=1, release rst_n, then read addr 63 and 0 -> init_done rises exactly 64 cycles after release; both reads return 16'h0000 with rd_valid 1 cycle after rd_gnt.
- Req0 writes 16'hBEEF to addr 62, next cycle req0 reads 62 -> wr_gnt[0] the first cycle, rd_gnt[0] the second, rd_valid[0] one cycle later with rd_data = 16'hBEEF.
- Req0 and req1 both hold rd_req for 4 cycles (addrs 60 and 61, preloaded 16'h0A0A and 16'h1B1B) -> grants alternate 0,1,0,1; rd_valid/rd_data alternate 0A0A, 1B1B with owner matching.
- Same cycle: req0 reads addr 5 (holds 16'h1111) while req1 writes 16'h2222 to addr 5 -> rd_data = 16'h1111; a following read of 5 returns 16'h2222.
- Requests held during INIT -> no grants and ram_read = 0 for 64 cycles; first grant on the first RUN cycle goes to requester 0.
- Assert rst_n low the cycle after a read grant -> rd_valid stays 0, all strobes 0 during reset, INIT restarts at address 0.

Source files
------------

// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants and types for the data-RAM access arbiter.
// The RAM geometry and FSM encodings live here so top and sub-module agree.
package ram_access_arbiter_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 16;

    // Highest word; it is also register A, so the clear walk ends here.
    localparam logic [RAM_ADDR_W-1:0] REG_A_ADDR = 6'd63;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] data;
    } ram_wr_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping),
// then moves ptr just past the winner. Grants are suppressed when en is low.
module rr_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    int               idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = 0;
        found = 1'b0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    ptr_d    = PTR_W'(rr_next(idx, NUM_REQ));
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one 64x16 read-first RAM between NUM_REQ requesters with independent
// round-robin read and write channels, after an optional clear-all sequence.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ        = 2,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [RAM_DATA_W-1:0] INIT_VALUE     = 16'h0000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               rd_req,
    input  logic [RAM_ADDR_W*NUM_REQ-1:0]    rd_addr,
    output logic [NUM_REQ-1:0]               rd_gnt,
    output logic [NUM_REQ-1:0]               rd_valid,
    output logic [RAM_DATA_W-1:0]            rd_data,
    input  logic [NUM_REQ-1:0]               wr_req,
    input  logic [RAM_ADDR_W*NUM_REQ-1:0]    wr_addr,
    input  logic [RAM_DATA_W*NUM_REQ-1:0]    wr_data,
    output logic [NUM_REQ-1:0]               wr_gnt,
    output logic                             init_done,
    output logic                             ram_read,
    output logic [RAM_ADDR_W-1:0]            ram_read_addr,
    output logic                             ram_write,
    output logic [RAM_ADDR_W-1:0]            ram_write_addr,
    output logic [RAM_DATA_W-1:0]            ram_data_in,
    input  logic [RAM_DATA_W-1:0]            ram_data_out
);

    localparam logic [0:0] RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

    logic [0:0]            state_q, state_d;
    logic [RAM_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
    logic                  in_run, in_init;
    logic [RAM_ADDR_W-1:0] rd_addr_sel;
    ram_wr_t               wr_sel;

    // rst_n gates these so no grant or strobe leaks out while reset is held.
    assign in_run  = rst_n && (state_q == ST_RUN);
    assign in_init = rst_n && (state_q == ST_INIT);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_run),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_run),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + 6'd1;
            if (clr_cnt_q == REG_A_ADDR) state_d = ST_RUN;
        end
    end

    // The registered one-hot grant doubles as the read owner.
    assign rd_valid_d = rd_gnt;

    always_comb begin
        rd_addr_sel = '0;
        wr_sel      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) rd_addr_sel = rd_addr_sel | rd_addr[RAM_ADDR_W*i +: RAM_ADDR_W];
            if (wr_gnt[i]) begin
                wr_sel.addr = wr_sel.addr | wr_addr[RAM_ADDR_W*i +: RAM_ADDR_W];
                wr_sel.data = wr_sel.data | wr_data[RAM_DATA_W*i +: RAM_DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            clr_cnt_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign ram_read       = |rd_gnt;
    assign ram_read_addr  = rd_addr_sel;
    assign ram_write      = in_init | (|wr_gnt);
    assign ram_write_addr = in_init ? clr_cnt_q  : wr_sel.addr;
    assign ram_data_in    = in_init ? INIT_VALUE : wr_sel.data;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = ram_data_out;
    assign init_done      = in_run;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench: a queue-and-array reference model predicts grants and
// read data; a negedge monitor pops expected reads whenever rd_valid fires.
module tb_ram_access_arbiter;

    localparam int          N      = 2;
    localparam logic [15:0] INIT_V = 16'h0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     rd_req, wr_req, rd_gnt, wr_gnt, rd_valid;
    logic [6*N-1:0]   rd_addr, wr_addr;
    logic [16*N-1:0]  wr_data;
    logic [15:0]      rd_data, ram_data_in, ram_data_out;
    logic             init_done, ram_read, ram_write;
    logic [5:0]       ram_read_addr, ram_write_addr;

    always #5 clk = ~clk;

    ram_access_arbiter #(.NUM_REQ(N), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT_V)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .init_done(init_done),
        .ram_read(ram_read), .ram_read_addr(ram_read_addr),
        .ram_write(ram_write), .ram_write_addr(ram_write_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // 64x16 read-first RAM with registered read data.
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (ram_read)  ram_data_out <= mem[ram_read_addr];
        if (ram_write) mem[ram_write_addr] <= ram_data_in;
    end

    typedef struct {
        int          owner;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [15:0] ref_mem [64];
    int          m_rd_ptr, m_wr_ptr, m_clr;
    bit          m_run;
    int          checks = 0, errors = 0;
    int          tick = 0;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Monitor: decoupled from the stimulus, pops whenever a read result shows.
    always @(negedge clk) begin
        if (rd_valid !== '0) begin
            if (sbq.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                check("rd_valid_owner", 32'(rd_valid), 32'(1 << mon_e.owner));
                check("rd_data", 32'(rd_data), 32'(mon_e.data));
                check("rd_latency", 32'(tick), 32'(mon_e.at));
            end
        end else if (sbq.size() > 0 && sbq[0].at <= tick) begin
            mon_e = sbq.pop_front();
            check("rd_valid_missing", 32'(rd_valid), 32'(1 << mon_e.owner));
        end
    end

    task automatic set_rd(input int i, input logic [5:0] a);
        rd_req[i] = 1'b1;
        rd_addr[6*i +: 6] = a;
    endtask

    task automatic set_wr(input int i, input logic [5:0] a, input logic [15:0] d);
        wr_req[i] = 1'b1;
        wr_addr[6*i +: 6] = a;
        wr_data[16*i +: 16] = d;
    endtask

    // Called at posedge+1 with inputs driven; returns at next posedge+1.
    task automatic step();
        int rg, wg;
        logic [N-1:0] erg, ewg;
        logic [5:0] a;
        #1;
        erg = '0; ewg = '0; rg = -1; wg = -1;
        if (m_run) begin
            rg = rr_pick(rd_req, m_rd_ptr);
            wg = rr_pick(wr_req, m_wr_ptr);
        end
        if (rg >= 0) erg[rg] = 1'b1;
        if (wg >= 0) ewg[wg] = 1'b1;
        check("rd_gnt", 32'(rd_gnt), 32'(erg));
        check("wr_gnt", 32'(wr_gnt), 32'(ewg));
        check("init_done", 32'(init_done), 32'(m_run));
        check("ram_read", 32'(ram_read), 32'(rg >= 0));
        if (!m_run) begin
            check("clr_write", 32'(ram_write), 32'h1);
            check("clr_addr", 32'(ram_write_addr), 32'(m_clr));
            check("clr_data", 32'(ram_data_in), 32'(INIT_V));
            ref_mem[m_clr] = INIT_V;
            m_clr++;
            if (m_clr == 64) m_run = 1'b1;
        end else begin
            check("ram_write", 32'(ram_write), 32'(wg >= 0));
            if (rg >= 0) begin
                a = rd_addr[6*rg +: 6];
                check("ram_read_addr", 32'(ram_read_addr), 32'(a));
                sbq.push_back('{rg, ref_mem[a], tick + 1});
                m_rd_ptr = (rg + 1) % N;
            end
            if (wg >= 0) begin
                a = wr_addr[6*wg +: 6];
                check("ram_write_addr", 32'(ram_write_addr), 32'(a));
                check("ram_data_in", 32'(ram_data_in), 32'(wr_data[16*wg +: 16]));
                ref_mem[a] = wr_data[16*wg +: 16];
                m_wr_ptr = (wg + 1) % N;
            end
        end
        @(posedge clk); #1;
        if (rg >= 0) rd_req[rg] = 1'b0;
        if (wg >= 0) wr_req[wg] = 1'b0;
    endtask

    task automatic reset_check();
        check("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        check("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        check("rst_ram_read", 32'(ram_read), 32'h0);
        check("rst_ram_write", 32'(ram_write), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sbq.delete();
        m_rd_ptr = 0; m_wr_ptr = 0; m_clr = 0; m_run = 1'b0;
        #1 reset_check();
        @(posedge clk); #1;
        reset_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_req | wr_req) != '0 && n < 20) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(rd_req | wr_req), 32'h0);
        repeat (2) step();
    endtask

    initial begin
        rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        // Requests held from reset through INIT: no grants may appear.
        set_rd(0, 6'd63);
        set_rd(1, 6'd0);
        set_wr(0, 6'd5, 16'h1111);
        apply_reset();
        repeat (64) step();
        drain();

        // Write then read back the same word on consecutive cycles.
        set_wr(0, 6'd62, 16'hBEEF);
        step();
        set_rd(0, 6'd62);
        step();
        drain();

        // Preload bank words, then two requesters contend for reads.
        set_wr(0, 6'd60, 16'h0A0A);
        set_wr(1, 6'd61, 16'h1B1B);
        drain();
        for (int c = 0; c < 4; c++) begin
            set_rd(0, 6'd60);
            set_rd(1, 6'd61);
            step();
        end
        drain();

        // Read and write of word 5 in one cycle: read sees the old value.
        set_rd(0, 6'd5);
        set_wr(1, 6'd5, 16'h2222);
        step();
        set_rd(0, 6'd5);
        step();
        drain();

        // Randomized traffic concentrated on a few addresses to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rd_req[i] && $urandom_range(0, 2) != 0)
                    set_rd(i, ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)));
                if (!wr_req[i] && $urandom_range(0, 2) == 0)
                    set_wr(i, 6'($urandom_range(0, 7)), 16'($urandom));
            end
            step();
        end
        drain();

        // Reset the cycle after a read grant: the result must be dropped.
        set_rd(0, 6'd3);
        step();
        set_rd(1, 6'd62);
        apply_reset();
        repeat (64) step();
        drain();
        set_rd(0, 6'd60);
        set_rd(1, 6'd5);
        drain();

        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
